// File: rtl/ahb3lite_sram_slave.sv
// rtl/ahb3lite_sram_slave.sv - AHB-Lite slave with word-organised SRAM, programmable wait states
// Define AHB3LITE_SRAM_ERR_EN to answer out-of-range, oversized and misaligned transfers with ERROR.
module ahb3lite_sram_slave #(
   parameter int          MEM_DEPTH   = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_STATES = 0
) (
   input  logic        i_hclk,
   input  logic        i_hresetn,
   input  logic        i_hsel,
   input  logic [31:0] i_haddr,
   input  logic [31:0] i_hwdata,
   input  logic        i_hwrite,
   input  logic [2:0]  i_hsize,
   input  logic [2:0]  i_hburst,
   input  logic [1:0]  i_htrans,
   input  logic        i_hready,
   output logic        o_hreadyout,
   output logic        o_hresp,
   output logic [31:0] o_hrdata
);

   localparam int AW = $clog2(MEM_DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

   state_t          r_state, w_state_nxt;
   logic [3:0]      r_cnt, w_cnt_nxt;
   logic            r_valid, w_valid_nxt;
   logic            r_write;
   logic [AW-1:0]   r_idx;
   logic [3:0]      r_lanes;
   logic [31:0]     r_mem [MEM_DEPTH];

   logic [31:0]     w_off;
   logic [3:0]      w_lanes;
   logic            w_accept;
   logic            w_err;
   logic            w_ready;
   logic            w_resp;
   logic            w_load;
   logic            w_done;
   logic            w_unused;

   assign w_off    = i_haddr - BASE_ADDR;
   assign w_accept = i_hsel & i_hready & i_htrans[1];
   assign w_unused = &{1'b0, i_hburst, w_off};

   // Lane selection ignores misaligned low bits; oversized transfers act as words.
   always_comb begin
      w_lanes = 4'b1111;
      case (i_hsize)
         3'd0:    w_lanes = 4'b0001 << i_haddr[1:0];
         3'd1:    w_lanes = i_haddr[1] ? 4'b1100 : 4'b0011;
         default: w_lanes = 4'b1111;
      endcase
   end

`ifdef AHB3LITE_SRAM_ERR_EN
   assign w_err = (w_off >= 32'(MEM_DEPTH * 4)) |
                  (i_hsize > 3'd2) |
                  ((i_hsize == 3'd1) & i_haddr[0]) |
                  ((i_hsize == 3'd2) & (i_haddr[1:0] != 2'b00));
`else
   assign w_err = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_valid_nxt = r_valid;
      w_ready     = 1'b1;
      w_resp      = 1'b0;
      case (r_state)
         ST_WAIT: begin
            w_ready = (r_cnt == 4'd0);
            if (r_cnt != 4'd0) w_cnt_nxt = r_cnt - 4'd1;
         end
         ST_ERR1: begin
            w_ready     = 1'b0;
            w_resp      = 1'b1;
            w_state_nxt = ST_ERR2;
         end
         ST_ERR2: w_resp = 1'b1;
         default: ;
      endcase
      // Any cycle with HREADYOUT high ends the current data phase and may start the next.
      if (w_ready) begin
         w_cnt_nxt   = 4'd0;
         w_valid_nxt = 1'b0;
         w_state_nxt = ST_IDLE;
         if (w_accept & w_err) begin
            w_state_nxt = ST_ERR1;
         end else if (w_accept) begin
            w_valid_nxt = 1'b1;
            w_cnt_nxt   = 4'(WAIT_STATES);
            if (WAIT_STATES > 0) w_state_nxt = ST_WAIT;
         end
      end
   end

   assign w_load = w_ready & w_accept & ~w_err;
   assign w_done = r_valid & w_ready;

   always_ff @(posedge i_hclk or negedge i_hresetn) begin
      if (!i_hresetn) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
         r_valid <= 1'b0;
         r_write <= 1'b0;
         r_idx   <= '0;
         r_lanes <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_valid <= w_valid_nxt;
         if (w_load) begin
            r_write <= i_hwrite;
            r_idx   <= w_off[AW+1:2];
            r_lanes <= w_lanes;
         end
      end
   end

   // Contents survive reset; a reset clears r_valid so a pending write never commits.
   always_ff @(posedge i_hclk) begin
      if (w_done & r_write) begin
         for (int b = 0; b < 4; b++) begin
            if (r_lanes[b]) r_mem[r_idx][8*b +: 8] <= i_hwdata[8*b +: 8];
         end
      end
   end

   assign o_hreadyout = w_ready;
   assign o_hresp     = w_resp;
   assign o_hrdata    = (w_done & ~r_write) ? r_mem[r_idx] : 32'h0;

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// tb/tb_ahb3lite_sram_slave.sv - table-driven scoreboard bench for ahb3lite_sram_slave
module tb_ahb3lite_sram_slave;

   localparam logic [31:0] BASE0 = 32'h0000_0000;
   localparam logic [31:0] BASE1 = 32'h0001_0000;
   localparam int          WS1   = 3;
`ifdef AHB3LITE_SRAM_ERR_EN
   localparam bit ERR = 1'b1;
`else
   localparam bit ERR = 1'b0;
`endif

   typedef struct {
      int          id;
      logic [1:0]  trans;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] off;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        hsel;
   logic [31:0] haddr;
   logic [31:0] hwdata;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [1:0]  htrans;
   int          sel;

   wire         rdy0, rdy1, resp0, resp1;
   wire  [31:0] rd0, rd1;
   wire         hsel0 = hsel & (sel == 0);
   wire         hsel1 = hsel & (sel == 1);
   wire         w_rdy  = (sel == 1) ? rdy1 : rdy0;
   wire         w_resp = (sel == 1) ? resp1 : resp0;
   wire  [31:0] w_rd   = (sel == 1) ? rd1 : rd0;

   int   errors = 0;
   int   checks = 0;
   vec_t vec[$];
   vec_t sb[$];

   always #5 clk = ~clk;

   ahb3lite_sram_slave #(.MEM_DEPTH(1024), .BASE_ADDR(BASE0), .WAIT_STATES(0)) u_dut0 (
      .i_hclk(clk), .i_hresetn(rst_n), .i_hsel(hsel0), .i_haddr(haddr), .i_hwdata(hwdata),
      .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst), .i_htrans(htrans),
      .i_hready(rdy0), .o_hreadyout(rdy0), .o_hresp(resp0), .o_hrdata(rd0));

   ahb3lite_sram_slave #(.MEM_DEPTH(1024), .BASE_ADDR(BASE1), .WAIT_STATES(WS1)) u_dut1 (
      .i_hclk(clk), .i_hresetn(rst_n), .i_hsel(hsel1), .i_haddr(haddr), .i_hwdata(hwdata),
      .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst), .i_htrans(htrans),
      .i_hready(rdy1), .o_hreadyout(rdy1), .o_hresp(resp1), .o_hrdata(rd1));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   function automatic void add(input logic [1:0] trans, input logic wr, input logic [2:0] size,
                               input logic [31:0] off, input logic [31:0] wdata,
                               input logic err, input logic [31:0] rdata);
      vec_t v;
      v = '{id: vec.size(), trans: trans, wr: wr, size: size, off: off, wdata: wdata,
            err: err, rdata: rdata};
      vec.push_back(v);
   endfunction

   task automatic run_vecs();
      int   idx = 0;
      int   waits = 0;
      int   expw;
      bit   in_dp = 0;
      bit   launched = 0;
      bit   bad = 0;
      logic rdy, rsp;
      logic [31:0] rd;
      vec_t c;
      sb.delete();
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         rdy = w_rdy;
         rsp = w_resp;
         rd  = w_rd;
         if (launched) begin
            in_dp = 1; waits = 0; bad = 0; launched = 0;
         end
         if (in_dp) begin
            c = sb[0];
            hwdata = c.wdata;
            if (rsp !== c.err) bad = 1;
            if (!rdy) begin
               waits++;
               if (rd !== 32'h0) bad = 1;
               if (waits > 20) begin
                  $display("FAIL timeout s%0d v%0d: hreadyout low %0d cycles, required release", sel, c.id, waits);
                  errors++; checks++;
                  hsel = 0; htrans = 2'd0; sb.delete(); vec.delete();
                  return;
               end
            end else begin
               expw = c.err ? 1 : (c.trans[1] ? ((sel == 1) ? WS1 : 0) : 0);
               chk($sformatf("waits s%0d v%0d", sel, c.id), 32'(waits), 32'(expw));
               chk($sformatf("hresp s%0d v%0d", sel, c.id), {31'd0, rsp}, {31'd0, c.err});
               chk($sformatf("hrdata s%0d v%0d", sel, c.id), rd, c.rdata);
               chk($sformatf("phase s%0d v%0d", sel, c.id), {31'd0, bad}, 32'd0);
               void'(sb.pop_front());
               in_dp = 0;
            end
         end else begin
            hwdata = 32'h0;
         end
         if (rdy) begin
            if (idx < vec.size()) begin
               hsel   = 1'b1;
               htrans = vec[idx].trans;
               hwrite = vec[idx].wr;
               hsize  = vec[idx].size;
               haddr  = ((sel == 1) ? BASE1 : BASE0) + vec[idx].off;
               hburst = 3'b001;
               sb.push_back(vec[idx]);
               idx++;
               launched = 1;
            end else begin
               hsel = 1'b0; htrans = 2'd0;
               vec.delete();
               return;
            end
         end
      end
      $display("FAIL budget s%0d: sequence did not finish, %0d of %0d beats issued", sel, idx, vec.size());
      errors++; checks++;
      vec.delete();
   endtask

   initial begin
      rst_n = 1'b0; hsel = 1'b0; haddr = 32'h0; hwdata = 32'h0; hwrite = 1'b0;
      hsize = 3'd0; hburst = 3'd0; htrans = 2'd0; sel = 0;
      #12;
      chk("reset hreadyout0", {31'd0, rdy0}, 32'd1);
      chk("reset hresp0", {31'd0, resp0}, 32'd0);
      chk("reset hrdata0", rd0, 32'h0);
      chk("reset hreadyout1", {31'd0, rdy1}, 32'd1);
      chk("reset hresp1", {31'd0, resp1}, 32'd0);
      chk("reset hrdata1", rd1, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // zero-wait slave at base 0: word, sub-word, burst with BUSY, error/wrap cases
      sel = 0;
      add(2'd2, 1, 3'd2, 32'h10, 32'hDEAD_BEEF, 0, 32'h0);
      add(2'd2, 0, 3'd2, 32'h10, 32'h0,         0, 32'hDEAD_BEEF);
      add(2'd2, 1, 3'd2, 32'h20, 32'h1122_3344, 0, 32'h0);
      add(2'd2, 1, 3'd0, 32'h21, 32'h0000_AA00, 0, 32'h0);
      add(2'd2, 1, 3'd1, 32'h22, 32'hBBCC_0000, 0, 32'h0);
      add(2'd2, 0, 3'd2, 32'h20, 32'h0,         0, 32'hBBCC_AA44);
      add(2'd2, 0, 3'd0, 32'h23, 32'h0,         0, 32'hBBCC_AA44);
      add(2'd0, 0, 3'd2, 32'h20, 32'h0,         0, 32'h0);
      add(2'd2, 1, 3'd2, 32'h40, 32'h1000_0040, 0, 32'h0);
      add(2'd3, 1, 3'd2, 32'h44, 32'h1000_0044, 0, 32'h0);
      add(2'd1, 1, 3'd2, 32'h40, 32'hFFFF_FFFF, 0, 32'h0);
      add(2'd3, 1, 3'd2, 32'h48, 32'h1000_0048, 0, 32'h0);
      add(2'd3, 1, 3'd2, 32'h4C, 32'h1000_004C, 0, 32'h0);
      add(2'd2, 0, 3'd2, 32'h40, 32'h0,         0, 32'h1000_0040);
      add(2'd2, 0, 3'd2, 32'h44, 32'h0,         0, 32'h1000_0044);
      add(2'd2, 0, 3'd2, 32'h48, 32'h0,         0, 32'h1000_0048);
      add(2'd2, 0, 3'd2, 32'h4C, 32'h0,         0, 32'h1000_004C);
      add(2'd2, 1, 3'd2, 32'h0,    32'h0BAD_F00D, 0,   32'h0);
      add(2'd2, 1, 3'd2, 32'h1000, 32'h1234_5678, ERR, 32'h0);
      add(2'd2, 0, 3'd2, 32'h0,    32'h0, 0, ERR ? 32'h0BAD_F00D : 32'h1234_5678);
      add(2'd2, 1, 3'd1, 32'h3,    32'hCAFE_0000, ERR, 32'h0);
      add(2'd0, 0, 3'd2, 32'h0,    32'h0, 0, 32'h0);
      add(2'd2, 0, 3'd2, 32'h0,    32'h0, 0, ERR ? 32'h0BAD_F00D : 32'hCAFE_5678);
      add(2'd2, 1, 3'd2, 32'h8,    32'h0102_0304, 0,   32'h0);
      add(2'd2, 1, 3'd3, 32'h8,    32'h5566_7788, ERR, 32'h0);
      add(2'd2, 0, 3'd2, 32'h8,    32'h0, 0, ERR ? 32'h0102_0304 : 32'h5566_7788);
      run_vecs();

      // three-wait-state slave at a non-zero base
      @(negedge clk);
      sel = 1;
      add(2'd2, 1, 3'd2, 32'h0,   32'hA5A5_A5A5, 0, 32'h0);
      add(2'd2, 0, 3'd2, 32'h0,   32'h0,         0, 32'hA5A5_A5A5);
      add(2'd2, 1, 3'd2, 32'h4,   32'h1357_9BDF, 0, 32'h0);
      add(2'd2, 0, 3'd2, 32'h4,   32'h0,         0, 32'h1357_9BDF);
      add(2'd2, 0, 3'd0, 32'h5,   32'h0,         0, 32'h1357_9BDF);
      add(2'd2, 1, 3'd2, 32'hFFC, 32'h1111_1111, 0, 32'h0);
      add(2'd2, 1, 3'd2, 32'hFFFF_FFFC, 32'h2222_2222, ERR, 32'h0);
      add(2'd2, 0, 3'd2, 32'hFFC, 32'h0, 0, ERR ? 32'h1111_1111 : 32'h2222_2222);
      run_vecs();

      // reset asserted in the middle of a waited write data phase
      @(negedge clk);
      hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2; haddr = BASE1; hwdata = 32'h0;
      @(negedge clk);
      hsel = 1'b0; htrans = 2'd0; hwdata = 32'hFFFF_FFFF;
      chk("rst mid wait hreadyout", {31'd0, rdy1}, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("rst async hreadyout", {31'd0, rdy1}, 32'd1);
      chk("rst async hresp", {31'd0, resp1}, 32'd0);
      chk("rst async hrdata", rd1, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      hwdata = 32'h0;
      add(2'd2, 0, 3'd2, 32'h0, 32'h0, 0, 32'hA5A5_A5A5);
      run_vecs();

      @(negedge clk);
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
